// File: rtl/pcie_tx_cmd_dispatch.sv
// Pops two-word DMA commands from the TX command FIFO and issues them as PCIe
// request descriptors, split so none crosses an MPS/MRRS-aligned boundary.
module pcie_tx_cmd_dispatch #(
    parameter int P_FIFO_DATA_WIDTH = 46,
    parameter int P_MAX_WR_LOG2     = 7,
    parameter int P_MAX_RD_LOG2     = 9
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic                         cmd_fifo_rd_en,
    input  logic [P_FIFO_DATA_WIDTH-1:0] cmd_fifo_rd_data,
    input  logic                         cmd_fifo_empty_n,
    output logic                         tx_req_valid,
    input  logic                         tx_req_ready,
    output logic                         tx_req_type,
    output logic [63:0]                  tx_req_addr,
    output logic [9:0]                   tx_req_dw_len,
    output logic [7:0]                   tx_req_tag,
    output logic                         tx_req_last,
    output logic                         cmd_drop
);

    typedef enum logic [1:0] {
        IDLE,
        POP1,
        CALC,
        ISSUE
    } state_t;

    state_t state;

    logic [1:0]  w0_type;
    logic [9:0]  w0_len;
    logic [31:0] w0_addr_hi;

    logic        cur_type;
    logic [63:0] cur_addr;
    logic [10:0] rem_dw;
    logic [7:0]  cur_tag;
    logic [10:0] chunk;
    logic [10:0] chunk_next;

    logic        unused_bits;

    // Largest DW count that fits before the next max-size-aligned boundary.
    function automatic logic [10:0] calc_chunk(
        input logic [10:0] rem,
        input logic [9:0]  addr_dw,
        input logic        is_rd
    );
        int          lg;
        logic [10:0] max_dw;
        logic [10:0] room;
        lg     = is_rd ? P_MAX_RD_LOG2 : P_MAX_WR_LOG2;
        max_dw = 11'd1 << (lg - 2);
        room   = max_dw - ({1'b0, addr_dw} & (max_dw - 11'd1));
        return (rem < room) ? rem : room;
    endfunction

    assign chunk_next = calc_chunk(rem_dw, cur_addr[11:2], cur_type);

    // The FIFO is show-ahead: the pop and the read of the head word share a cycle.
    assign cmd_fifo_rd_en = ((state == IDLE) && cmd_fifo_empty_n) || (state == POP1);

    assign unused_bits = ^{cmd_fifo_rd_data[33:32], cmd_fifo_rd_data[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            tx_req_valid  <= 1'b0;
            tx_req_type   <= 1'b0;
            tx_req_addr   <= '0;
            tx_req_dw_len <= '0;
            tx_req_tag    <= '0;
            tx_req_last   <= 1'b0;
            cmd_drop      <= 1'b0;
        end else begin
            cmd_drop <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_fifo_empty_n) begin
                        state <= POP1;
                    end
                end
                POP1: begin
                    if (w0_type[1]) begin
                        cmd_drop <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    tx_req_valid  <= 1'b1;
                    tx_req_type   <= cur_type;
                    tx_req_addr   <= cur_addr;
                    tx_req_dw_len <= chunk_next[9:0];
                    tx_req_tag    <= cur_tag;
                    tx_req_last   <= (chunk_next == rem_dw);
                    state         <= ISSUE;
                end
                ISSUE: begin
                    if (tx_req_ready) begin
                        tx_req_valid <= 1'b0;
                        state        <= tx_req_last ? IDLE : CALC;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Command datapath; every register is loaded before the FSM reads it.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (cmd_fifo_empty_n) begin
                    w0_type    <= cmd_fifo_rd_data[45:44];
                    w0_len     <= cmd_fifo_rd_data[43:34];
                    w0_addr_hi <= cmd_fifo_rd_data[31:0];
                end
            end
            POP1: begin
                cur_type <= w0_type[0];
                cur_addr <= {w0_addr_hi, cmd_fifo_rd_data[31:2], 2'b00};
                rem_dw   <= (w0_len == 10'd0) ? 11'd1024 : {1'b0, w0_len};
                cur_tag  <= cmd_fifo_rd_data[45:38];
            end
            CALC: begin
                chunk <= chunk_next;
            end
            ISSUE: begin
                if (tx_req_ready) begin
                    cur_addr <= cur_addr + {51'd0, chunk, 2'b00};
                    rem_dw   <= rem_dw - chunk;
                    cur_tag  <= cur_tag + 8'd1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pcie_tx_cmd_dispatch.sv
// Bench for pcie_tx_cmd_dispatch: FIFO model, descriptor monitor and a
// boundary-splitting reference model driven by directed and random commands.
module tb_pcie_tx_cmd_dispatch;

    localparam int WR_LOG2 = 7;
    localparam int RD_LOG2 = 9;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_en;
    logic [45:0] fifo_data;
    logic        fifo_empty_n;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        tx_type;
    logic [63:0] tx_addr;
    logic [9:0]  tx_len;
    logic [7:0]  tx_tag;
    logic        tx_last;
    logic        drop;

    always #5 clk = ~clk;

    pcie_tx_cmd_dispatch #(
        .P_FIFO_DATA_WIDTH(46),
        .P_MAX_WR_LOG2    (WR_LOG2),
        .P_MAX_RD_LOG2    (RD_LOG2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd_fifo_rd_en  (rd_en),
        .cmd_fifo_rd_data(fifo_data),
        .cmd_fifo_empty_n(fifo_empty_n),
        .tx_req_valid    (tx_valid),
        .tx_req_ready    (tx_ready),
        .tx_req_type     (tx_type),
        .tx_req_addr     (tx_addr),
        .tx_req_dw_len   (tx_len),
        .tx_req_tag      (tx_tag),
        .tx_req_last     (tx_last),
        .cmd_drop        (drop)
    );

    typedef struct packed {
        logic        typ;
        logic [63:0] addr;
        logic [9:0]  len;
        logic [7:0]  tag;
        logic        last;
    } desc_t;

    logic [45:0] fq[$];
    desc_t       obs[$];
    int          obs_cyc[$];
    desc_t       exp_q[$];
    int          pops, drops, exp_drops, exp_pops, cyc;
    int          n_checks = 0;
    int          n_fail = 0;

    // Show-ahead FIFO, cleared by the shared reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fq.delete();
            fifo_data    <= '0;
            fifo_empty_n <= 1'b0;
        end else begin
            if (rd_en && fq.size() > 0) fq.delete(0);
            fifo_data    <= (fq.size() > 0) ? fq[0] : '0;
            fifo_empty_n <= (fq.size() >= 2);
        end
    end

    // Mid-cycle monitor: a valid&ready seen here is accepted at the next edge.
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (tx_valid && tx_ready) begin
                obs.push_back('{tx_type, tx_addr, tx_len, tx_tag, tx_last});
                obs_cyc.push_back(cyc);
            end
            if (rd_en) pops++;
            if (drop) drops++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_sb();
        obs.delete(); obs_cyc.delete(); exp_q.delete();
        pops = 0; drops = 0; exp_drops = 0; exp_pops = 0;
    endtask

    // Pushes a command (reserved bits randomised) and appends its expected descriptors.
    task automatic push_cmd(input logic [1:0] t, input logic [9:0] len,
                            input logic [63:0] addr, input logic [7:0] tag);
        logic [45:0] w0, w1;
        logic [63:0] a;
        logic [7:0]  tg;
        int          rem, room, n, maxb;
        w0 = {t, len, 2'($urandom), addr[63:32]};
        w1 = {tag, 6'($urandom), addr[31:2], 2'($urandom)};
        fq.push_back(w0);
        fq.push_back(w1);
        exp_pops += 2;
        if (t[1]) begin
            exp_drops++;
        end else begin
            a    = {addr[63:2], 2'b00};
            rem  = (len == 10'd0) ? 1024 : int'(len);
            maxb = t[0] ? (1 << RD_LOG2) : (1 << WR_LOG2);
            tg   = tag;
            while (rem > 0) begin
                room = (maxb - int'(a % 64'(maxb))) / 4;
                n    = (rem < room) ? rem : room;
                exp_q.push_back('{typ: t[0], addr: a, len: n[9:0], tag: tg, last: (n == rem)});
                a   = a + 64'(n * 4);
                rem = rem - n;
                tg  = tg + 8'd1;
            end
        end
    endtask

    task automatic run_until(input int ready_pct, input int budget, output bit timed_out);
        int k;
        k = 0;
        timed_out = 1'b0;
        while (!(obs.size() >= exp_q.size() && fq.size() == 0 && !tx_valid && pops >= exp_pops)) begin
            @(posedge clk); #1;
            tx_ready = (int'($urandom_range(99)) < ready_pct);
            k++;
            if (k > budget) begin
                timed_out = 1'b1;
                break;
            end
        end
        repeat (8) begin
            @(posedge clk); #1;
            tx_ready = 1'b1;
        end
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", tx_valid); end
        n_checks++;
        if ({rd_en, drop} !== 2'b00) begin n_fail++; $display("FAIL reset_rd_en_drop got %b want 00", {rd_en, drop}); end
        n_checks++;
        if ({tx_type, tx_addr, tx_len, tx_tag, tx_last} !== '0) begin
            n_fail++; $display("FAIL reset_fields got %h want 0", {tx_type, tx_addr, tx_len, tx_tag, tx_last});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic test_single_mwr();
        bit        to;
        int        k, lat;
        logic [7:0] t;
        clear_sb();
        t = 8'($urandom);
        tx_ready = 1'b1;
        push_cmd(2'b00, 10'd16, 64'h1000, t);
        k = 0;
        while (!fifo_empty_n && k < 10) begin @(negedge clk); k++; end
        lat = 0;
        while (!tx_valid && lat < 10) begin @(negedge clk); lat++; end
        n_checks++;
        if (lat !== 3) begin n_fail++; $display("FAIL single_latency got %0d want 3", lat); end
        run_until(100, 200, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL single_timeout got %0d descs want %0d", obs.size(), exp_q.size()); end
        n_checks++;
        if (obs.size() !== 1) begin n_fail++; $display("FAIL single_count got %0d want 1", obs.size()); end
        else begin
            n_checks++;
            if (obs[0] !== {1'b0, 64'h1000, 10'd16, t, 1'b1}) begin
                n_fail++; $display("FAIL single_desc got %h want %h", obs[0], {1'b0, 64'h1000, 10'd16, t, 1'b1});
            end
        end
        n_checks++;
        if (pops !== 2) begin n_fail++; $display("FAIL single_pops got %0d want 2", pops); end
    endtask

    task automatic test_split_mwr();
        bit          to;
        logic [7:0]  t;
        logic [63:0] ea[3];
        logic [9:0]  el[3];
        clear_sb();
        t = 8'($urandom);
        ea[0] = 64'h1_0000_0FC0; ea[1] = 64'h1_0000_1000; ea[2] = 64'h1_0000_1080;
        el[0] = 10'd16;          el[1] = 10'd32;          el[2] = 10'd16;
        push_cmd(2'b00, 10'd64, 64'h1_0000_0FC0, t);
        run_until(100, 300, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL split_timeout got %0d descs want 3", obs.size()); end
        n_checks++;
        if (obs.size() !== 3) begin n_fail++; $display("FAIL split_count got %0d want 3", obs.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs[i] !== {1'b0, ea[i], el[i], 8'(t + 8'(i)), (i == 2)}) begin
                    n_fail++; $display("FAIL split_desc[%0d] got %h want %h", i, obs[i], {1'b0, ea[i], el[i], 8'(t + 8'(i)), (i == 2)});
                end
            end
            for (int i = 1; i < 3; i++) begin
                n_checks++;
                if (obs_cyc[i] - obs_cyc[i-1] !== 2) begin
                    n_fail++; $display("FAIL split_spacing[%0d] got %0d cycles want 2", i, obs_cyc[i] - obs_cyc[i-1]);
                end
            end
        end
        n_checks++;
        if (pops !== 2) begin n_fail++; $display("FAIL split_pops got %0d want 2", pops); end
    endtask

    task automatic test_mrd_wrap();
        bit to;
        clear_sb();
        push_cmd(2'b01, 10'd0, 64'h2000, 8'hFE);
        run_until(100, 400, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL mrd_timeout got %0d descs want 8", obs.size()); end
        n_checks++;
        if (obs.size() !== 8) begin n_fail++; $display("FAIL mrd_count got %0d want 8", obs.size()); end
        else begin
            for (int k = 0; k < 8; k++) begin
                n_checks++;
                if (obs[k] !== {1'b1, 64'h2000 + 64'(k * 'h200), 10'd128, 8'(8'hFE + 8'(k)), (k == 7)}) begin
                    n_fail++; $display("FAIL mrd_desc[%0d] got %h want %h", k, obs[k], {1'b1, 64'h2000 + 64'(k * 'h200), 10'd128, 8'(8'hFE + 8'(k)), (k == 7)});
                end
            end
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            n_checks++;
            if (obs[i] !== exp_q[i]) begin n_fail++; $display("FAIL mrd_model[%0d] got %h want %h", i, obs[i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        bit    to;
        int    k, p0;
        desc_t snap;
        clear_sb();
        tx_ready = 1'b0;
        push_cmd(2'b00, 10'd8, 64'h3000 + 64'({$urandom_range(15), 5'b0}), 8'($urandom));
        k = 0;
        while (!tx_valid && k < 20) begin @(negedge clk); k++; end
        n_checks++;
        if (!tx_valid) begin n_fail++; $display("FAIL bp_valid_timeout got %b want 1", tx_valid); end
        snap = '{tx_type, tx_addr, tx_len, tx_tag, tx_last};
        p0 = pops;
        repeat (5) begin
            @(negedge clk); #1;
            n_checks++;
            if ({tx_valid, tx_type, tx_addr, tx_len, tx_tag, tx_last} !== {1'b1, snap}) begin
                n_fail++; $display("FAIL bp_hold got %h want %h", {tx_valid, tx_type, tx_addr, tx_len, tx_tag, tx_last}, {1'b1, snap});
            end
        end
        n_checks++;
        if (pops !== p0) begin n_fail++; $display("FAIL bp_pops got %0d want %0d", pops, p0); end
        @(posedge clk); #1;
        tx_ready = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (obs.size() !== 1) begin n_fail++; $display("FAIL bp_accept got %0d descs want 1", obs.size()); end
        @(posedge clk); #1;
        n_checks++;
        if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_after got %b want 0", tx_valid); end
        run_until(100, 100, to);
        n_checks++;
        if (obs.size() !== exp_q.size()) begin n_fail++; $display("FAIL bp_count got %0d want %0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            n_checks++;
            if (obs[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_desc[%0d] got %h want %h", i, obs[i], exp_q[i]); end
        end
    endtask

    task automatic test_reserved();
        bit to;
        clear_sb();
        tx_ready = 1'b1;
        push_cmd(2'b10, 10'($urandom), {$urandom, $urandom}, 8'($urandom));
        push_cmd(2'b00, 10'd4, 64'h4000, 8'h3C);
        run_until(100, 200, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL rsv_timeout got %0d descs want %0d", obs.size(), exp_q.size()); end
        n_checks++;
        if (drops !== 1) begin n_fail++; $display("FAIL rsv_drops got %0d want 1", drops); end
        n_checks++;
        if (pops !== 4) begin n_fail++; $display("FAIL rsv_pops got %0d want 4", pops); end
        n_checks++;
        if (obs.size() !== 1) begin n_fail++; $display("FAIL rsv_count got %0d want 1", obs.size()); end
        else begin
            n_checks++;
            if (obs[0] !== {1'b0, 64'h4000, 10'd4, 8'h3C, 1'b1}) begin
                n_fail++; $display("FAIL rsv_desc got %h want %h", obs[0], {1'b0, 64'h4000, 10'd4, 8'h3C, 1'b1});
            end
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        int k;
        clear_sb();
        tx_ready = 1'b1;
        push_cmd(2'b00, 10'd64, 64'h1_0000_0FC0, 8'($urandom));
        k = 0;
        while (obs.size() < 1 && k < 20) begin @(negedge clk); #1; k++; end
        @(posedge clk); #1;
        tx_ready = 1'b0;
        k = 0;
        while (!tx_valid && k < 10) begin @(negedge clk); k++; end
        n_checks++;
        if (!tx_valid || tx_addr !== 64'h1_0000_1000) begin
            n_fail++; $display("FAIL rstmid_second got valid %b addr %h want 1 100001000", tx_valid, tx_addr);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({tx_valid, rd_en, tx_addr} !== '0) begin
            n_fail++; $display("FAIL rstmid_async got %h want 0", {tx_valid, rd_en, tx_addr});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_sb();
        tx_ready = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        n_checks++;
        if (obs.size() !== 0 || pops !== 0 || tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_quiet got %0d descs %0d pops valid %b want 0 0 0", obs.size(), pops, tx_valid);
        end
        push_cmd(2'b01, 10'd200, 64'h5000_0000_0000_0180, 8'h77);
        run_until(100, 300, to);
        n_checks++;
        if (obs.size() !== exp_q.size()) begin n_fail++; $display("FAIL rstmid_count got %0d want %0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            n_checks++;
            if (obs[i] !== exp_q[i]) begin n_fail++; $display("FAIL rstmid_desc[%0d] got %h want %h", i, obs[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        bit          to;
        logic [1:0]  t;
        logic [9:0]  len;
        logic [63:0] a;
        clear_sb();
        push_cmd(2'b00, 10'd32, 64'h0000_0000_FFFF_FFC0, 8'hF0);
        for (int c = 0; c < 24; c++) begin
            t = ($urandom_range(9) == 0) ? {1'b1, 1'($urandom)} : {1'b0, 1'($urandom)};
            case ($urandom_range(3))
                0:       len = 10'd0;
                1:       len = 10'($urandom);
                default: len = 10'($urandom_range(1, 40));
            endcase
            a = {$urandom, $urandom};
            if ($urandom_range(1) == 0) a[11:0] = 12'hFF0 | 12'($urandom_range(15));
            push_cmd(t, len, a, 8'($urandom));
        end
        run_until(70, 40000, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL rand_timeout got %0d descs want %0d", obs.size(), exp_q.size()); end
        n_checks++;
        if (obs.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand_count got %0d want %0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            n_checks++;
            if (obs[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_desc[%0d] got %h want %h", i, obs[i], exp_q[i]); end
        end
        n_checks++;
        if (pops !== exp_pops) begin n_fail++; $display("FAIL rand_pops got %0d want %0d", pops, exp_pops); end
        n_checks++;
        if (drops !== exp_drops) begin n_fail++; $display("FAIL rand_drops got %0d want %0d", drops, exp_drops); end
    endtask

    initial begin
        pops = 0; drops = 0; exp_drops = 0; exp_pops = 0; cyc = 0;
        test_reset();
        test_single_mwr();
        test_split_mwr();
        test_mrd_wrap();
        test_backpressure();
        test_reserved();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pcie_tx_cmd_dispatch.md
Name: pcie_tx_cmd_dispatch

Overview:
Consumer end of the PCIe TX command FIFO. It pops two-word DMA commands from the FIFO read port and assembles each into a host address, length, type and tag. It then issues the command to the PCIe TX engine as a stream of request descriptors over a valid/ready handshake. Each descriptor is split so it never crosses a max-size-aligned boundary, and therefore never crosses a 4 KB boundary.

Parameters:
P_FIFO_DATA_WIDTH, 46, width of one command FIFO word; the layout below is fixed for 46.
P_MAX_WR_LOG2, 7, log2 of the max write payload in bytes (MPS); legal range 7..12.
P_MAX_RD_LOG2, 9, log2 of the max read request in bytes (MRRS); legal range 7..12.

Ports:
clk  in  1  block clock
rst_n  in  1  reset; asynchronous assert, active-low
cmd_fifo_rd_en  out  1  pop one word from the command FIFO
cmd_fifo_rd_data  in  46  head word of the FIFO; the new head is visible the cycle after rd_en
cmd_fifo_empty_n  in  1  high = at least one complete 2-word command is present
tx_req_valid  out  1  descriptor valid
tx_req_ready  in  1  TX engine accepts the descriptor
tx_req_type  out  1  0 = MWr, 1 = MRd
tx_req_addr  out  64  byte address; bits [1:0] are always 0
tx_req_dw_len  out  10  DW count; 0 encodes 1024 (PCIe encoding)
tx_req_tag  out  8  request tag
tx_req_last  out  1  final descriptor of the command
cmd_drop  out  1  1-cycle pulse when a reserved-type command is discarded

Behaviour:
- Command word 0:
  - [45:44] type: 00 = MWr, 01 = MRd, 1x = reserved.
  - [43:34] dw_len: 0 means 1024.
  - [33:32] reserved.
  - [31:0] addr[63:32].
- Command word 1:
  - [45:38] tag_base.
  - [37:32] reserved.
  - [31:2] addr[31:2].
  - [1:0] ignored.
- FSM states: IDLE, POP1, CALC, ISSUE.
- IDLE:
  - If empty_n = 1: latch word0 from rd_data, assert rd_en, go to POP1.
  - Otherwise stay in IDLE.
- POP1:
  - Latch word1, assert rd_en.
  - If type is reserved: pulse cmd_drop, go to IDLE.
  - Otherwise go to CALC.
  - Do not re-check empty_n here; the pair is guaranteed complete.
- CALC: register chunk = min(rem_dw, MAX_DW − addr[L−1:2]), where:
  - L = P_MAX_WR_LOG2 for MWr, P_MAX_RD_LOG2 for MRd.
  - MAX_DW = 2^(L−2).
  - rem_dw is 11 bits; it loads 1024 when dw_len = 0.
  - Load the tx_req_* output registers; go to ISSUE.
- ISSUE:
  - tx_req_valid = 1; all tx_req_* fields are held stable until handshake.
  - tx_req_last = (chunk == rem_dw).
  - On valid & ready:
    - addr += chunk×4 (64-bit add, carry into the upper word).
    - rem_dw −= chunk.
    - tag += 1, modulo 256.
    - If last, go to IDLE; otherwise go to CALC.
- Tags: the first descriptor uses tag_base, and tags increment per descriptor for both types.
- Output encoding: tx_req_dw_len = chunk[9:0], so a chunk of 1024 is output as 0.
- Throughput: at most one descriptor every 2 cycles. Command latency is 3 cycles from empty_n sampled high in IDLE to tx_req_valid.
- rd_en is asserted only in IDLE (with empty_n) and in POP1: exactly 2 pops per command, never a pop while empty_n = 0 in IDLE.
- Reset values: rd_en = 0, tx_req_valid = 0, cmd_drop = 0, all tx_req_* fields = 0, FSM = IDLE.
- Reset mid-command abandons the command with no partial descriptor. The FIFO shares rst_n and is cleared in the same reset.
- tx_req_ready sampled while valid = 0 is ignored.

Test Plan:
- MWr, dw_len = 16, addr 0x0000_0000_0000_1000 → one descriptor: addr 0x1000, len 16, last = 1, tag = tag_base; exactly 2 rd_en pulses.
- MWr, dw_len = 64, addr 0x0000_0001_0000_0FC0, MPS 128 B → three descriptors:
  - 0x1_0000_0FC0, len 16.
  - 0x1_0000_1000, len 32.
  - 0x1_0000_1080, len 16, last.
  - Tags t, t+1, t+2.
- MRd, dw_len = 0 (1024 DW), addr 0x2000, tag_base 0xFE, MRRS 512 B → 8 descriptors of len 128 at 0x2000 + k×0x200; tags FE, FF, 00 .. 05 (wrap); last only on the 8th.
- Backpressure: hold ready = 0 for 5 cycles during ISSUE → all fields stable, no additional rd_en, descriptor accepted on the first ready = 1.
- Reserved type 2'b10 → 2 pops, one cmd_drop pulse, no tx_req_valid; a following valid MWr is then issued normally.
- Assert rst_n low during ISSUE of the 2nd of 3 descriptors → tx_req_valid drops immediately (asynchronous); after release, FSM is in IDLE and no descriptor is emitted until a new command arrives.
